// File: rtl/imem_block_responder.sv
// Instruction-memory responder for icache block refills. A block request waits
// m_latency cycles, then reads one word per cycle from a word-wide array and
// returns the assembled block with a single-cycle done pulse. A word-wide load
// port preloads program text and may write in any state.
module imem_block_responder #(
  parameter int unsigned c_line_size  = 32,
  parameter int unsigned c_block_size = 2,
  parameter int unsigned address_size = 32,
  parameter int unsigned m_depth      = 8,
  parameter int unsigned m_latency    = 3
) (
  input  logic                                          clk_i,
  input  logic                                          reset_i,
  input  logic                                          m_read_en_i,
  input  logic [address_size-c_block_size-3:0]          m_address_i,
  output logic                                          m_busywait_o,
  output logic [(2**c_block_size)*c_line_size-1:0]      m_read_data_o,
  output logic                                          m_read_done_o,
  input  logic                                          load_en_i,
  input  logic [m_depth+c_block_size-1:0]               load_addr_i,
  input  logic [c_line_size-1:0]                        load_data_i
);

  localparam int unsigned Words    = 2 ** c_block_size;
  localparam int unsigned BlockW   = Words * c_line_size;
  localparam int unsigned BlkAddrW = address_size - c_block_size - 2;
  localparam int unsigned WordIdxW = m_depth + c_block_size;
  localparam int unsigned MemWords = 2 ** WordIdxW;
  localparam int unsigned CntW     = (m_latency > 0) ? $clog2(m_latency + 1) : 1;

  typedef enum logic [1:0] {StIdle, StWait, StFill, StDone} state_e;

  state_e                    state_q;
  logic [CntW-1:0]           cnt_q;
  logic [c_block_size-1:0]   beat_q;
  logic [m_depth-1:0]        addr_q;
  logic                      busy_q;
  logic                      done_q;
  logic [BlockW-1:0]         data_q;

  logic [c_line_size-1:0]    mem [MemWords];
  logic [c_line_size-1:0]    rd_word;

  // Block-address bits above m_depth alias onto the stored blocks.
  logic unused_addr_hi;
  assign unused_addr_hi = ^m_address_i[BlkAddrW-1:m_depth];

  // Current fill beat; sampled before any same-edge preload write lands.
  assign rd_word = mem[{addr_q, beat_q}];

  // Preload port: array contents are deliberately never reset.
  always_ff @(posedge clk_i) begin
    if (load_en_i) begin
      mem[load_addr_i] <= load_data_i;
    end
  end

  // Request FSM with registered busy/done/data outputs.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      beat_q  <= '0;
      addr_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      data_q  <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (m_read_en_i) begin
            addr_q <= m_address_i[m_depth-1:0];
            busy_q <= 1'b1;
            data_q <= '0;
            beat_q <= '0;
            if (m_latency == 0) begin
              state_q <= StFill;
            end else begin
              cnt_q   <= CntW'(m_latency);
              state_q <= StWait;
            end
          end
        end
        StWait: begin
          if (!m_read_en_i) begin
            busy_q  <= 1'b0;
            state_q <= StIdle;
          end else begin
            cnt_q <= cnt_q - CntW'(1);
            if (cnt_q == CntW'(1)) begin
              beat_q  <= '0;
              state_q <= StFill;
            end
          end
        end
        StFill: begin
          if (!m_read_en_i) begin
            busy_q  <= 1'b0;
            state_q <= StIdle;
          end else begin
            for (int unsigned k = 0; k < Words; k++) begin
              if (beat_q == c_block_size'(k)) begin
                data_q[k*c_line_size +: c_line_size] <= rd_word;
              end
            end
            beat_q <= beat_q + 1'b1;
            if (beat_q == c_block_size'(Words - 1)) begin
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= StDone;
            end
          end
        end
        StDone: begin
          // Never re-accept here; the icache drops its request during done.
          done_q  <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign m_busywait_o  = busy_q;
  assign m_read_done_o = done_q;
  assign m_read_data_o = data_q;

endmodule

// File: tb/tb_imem_block_responder.sv
// Bench for imem_block_responder: one instance with latency 3, one with latency 0.
// Expected blocks are queued when a request is issued and checked on done.
module tb_imem_block_responder;

  localparam int unsigned LineW = 32;
  localparam int unsigned BlkW  = 2;
  localparam int unsigned AddrW = 32;
  localparam int unsigned Depth = 8;
  localparam int unsigned BaW   = AddrW - BlkW - 2;
  localparam int unsigned DataW = (2 ** BlkW) * LineW;
  localparam int unsigned WaW   = Depth + BlkW;

  typedef struct packed {
    logic [DataW-1:0] data;
    logic [31:0]      lat;
  } exp_t;

  logic clk_i = 1'b0;
  logic reset_i = 1'b0;
  always #5 clk_i = ~clk_i;

  logic             rd_en     [2];
  logic [BaW-1:0]   addr      [2];
  logic             busy      [2];
  logic [DataW-1:0] data      [2];
  logic             done      [2];
  logic             load_en   [2];
  logic [WaW-1:0]   load_addr [2];
  logic [LineW-1:0] load_data [2];

  imem_block_responder #(.m_latency(3)) dut_lat3 (
    .clk_i         (clk_i),
    .reset_i       (reset_i),
    .m_read_en_i   (rd_en[0]),
    .m_address_i   (addr[0]),
    .m_busywait_o  (busy[0]),
    .m_read_data_o (data[0]),
    .m_read_done_o (done[0]),
    .load_en_i     (load_en[0]),
    .load_addr_i   (load_addr[0]),
    .load_data_i   (load_data[0])
  );

  imem_block_responder #(.m_latency(0)) dut_lat0 (
    .clk_i         (clk_i),
    .reset_i       (reset_i),
    .m_read_en_i   (rd_en[1]),
    .m_address_i   (addr[1]),
    .m_busywait_o  (busy[1]),
    .m_read_data_o (data[1]),
    .m_read_done_o (done[1]),
    .load_en_i     (load_en[1]),
    .load_addr_i   (load_addr[1]),
    .load_data_i   (load_data[1])
  );

  int   vectors = 0;
  int   miscompares = 0;
  exp_t exp_q0 [$];
  exp_t exp_q1 [$];

  task automatic chk(string name, logic [DataW-1:0] got, logic [DataW-1:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  // Monitor: cycle stamps for busy rise, then pop/compare on each done pulse.
  int   cyc = 0;
  int   rise [2] = '{0, 0};
  logic busy_d [2] = '{1'b0, 1'b0};
  exp_t mon_e;
  bit   have_e;

  always @(posedge clk_i) cyc <= cyc + 1;

  always @(negedge clk_i) begin
    for (int k = 0; k < 2; k++) begin
      if (busy[k] === 1'b1 && busy_d[k] !== 1'b1) rise[k] = cyc;
      busy_d[k] = busy[k];
      if (done[k] === 1'b1) begin
        have_e = 1'b0;
        if (k == 0 && exp_q0.size() > 0) begin
          mon_e = exp_q0.pop_front();
          have_e = 1'b1;
        end else if (k == 1 && exp_q1.size() > 0) begin
          mon_e = exp_q1.pop_front();
          have_e = 1'b1;
        end
        if (!have_e) begin
          chk("unexpected_done", 1, 0);
        end else begin
          chk("block_data", data[k], mon_e.data);
          chk("done_latency", DataW'(cyc - rise[k]), DataW'(mon_e.lat));
          chk("busy_low_at_done", DataW'(busy[k]), 0);
        end
      end
    end
  end

  task automatic load(int k, int unsigned wa, logic [LineW-1:0] d);
    load_en[k]   = 1'b1;
    load_addr[k] = WaW'(wa);
    load_data[k] = d;
    @(posedge clk_i);
    #1 load_en[k] = 1'b0;
  endtask

  // Issue a block request, hold it until done, then let the FSM return to idle.
  task automatic request(int k, logic [BaW-1:0] ba, logic [DataW-1:0] want, int unsigned lat);
    exp_t e;
    bit   seen = 1'b0;
    e.data = want;
    e.lat  = lat;
    if (k == 0) exp_q0.push_back(e);
    else        exp_q1.push_back(e);
    rd_en[k] = 1'b1;
    addr[k]  = ba;
    @(posedge clk_i);
    #1 addr[k] = '1;  // the captured address must be the one used
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk_i);
      if (done[k] === 1'b1) seen = 1'b1;
    end
    rd_en[k] = 1'b0;
    if (!seen) begin
      chk("done_timeout", 0, 1);
      if (k == 0) exp_q0.delete();
      else        exp_q1.delete();
    end
    @(posedge clk_i);
    #1;
  endtask

  localparam logic [DataW-1:0] Blk0 = {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};
  localparam logic [DataW-1:0] Blk1 = {32'h88888888, 32'h77777777, 32'h66666666, 32'h55555555};
  localparam logic [DataW-1:0] Blk3 = {32'hC3C3C3C3, 32'hC2C2C2C2, 32'hC1C1C1C1, 32'hC0C0C0C0};
  localparam logic [DataW-1:0] Blk0New = {32'h44444444, 32'h33333333, 32'hDEADBEEF, 32'h11111111};
  localparam logic [DataW-1:0] Blk5 = {32'h000000A3, 32'h000000A2, 32'h000000A1, 32'h000000A0};

  initial begin
    for (int k = 0; k < 2; k++) begin
      rd_en[k] = 1'b0; addr[k] = '0; load_en[k] = 1'b0; load_addr[k] = '0; load_data[k] = '0;
    end
    #2 reset_i = 1'b1;
    #1;
    chk("reset_busy", DataW'(busy[0]), 0);
    chk("reset_done", DataW'(done[0]), 0);
    chk("reset_data", data[0], 0);
    repeat (2) @(posedge clk_i);
    #1 reset_i = 1'b0;
    @(posedge clk_i);
    #1;

    // Preload blocks 0, 1 and 3 of the latency-3 instance, block 5 of the other.
    for (int i = 0; i < 4; i++) begin
      load(0, i,      Blk0[i*LineW +: LineW]);
      load(0, 4 + i,  Blk1[i*LineW +: LineW]);
      load(0, 12 + i, Blk3[i*LineW +: LineW]);
      load(1, 20 + i, Blk5[i*LineW +: LineW]);
    end

    request(0, 0, Blk0, 7);
    request(1, 5, Blk5, 4);
    request(0, 1, Blk1, 7);
    request(0, 257, Blk1, 7);  // aliases to block 1

    // Abort during fill beat 2: no done; a following request completes normally.
    rd_en[0] = 1'b1;
    addr[0]  = 3;
    repeat (6) @(posedge clk_i);
    #1 rd_en[0] = 1'b0;
    @(posedge clk_i);
    #1;
    chk("abort_busy", DataW'(busy[0]), 0);
    @(posedge clk_i);
    #1;
    request(0, 3, Blk3, 7);

    // Asynchronous reset while waiting.
    rd_en[0] = 1'b1;
    addr[0]  = 0;
    repeat (2) @(posedge clk_i);
    #1;
    chk("wait_busy_before_reset", DataW'(busy[0]), 1);
    reset_i = 1'b1;
    #1;
    chk("async_reset_busy", DataW'(busy[0]), 0);
    chk("async_reset_done", DataW'(done[0]), 0);
    chk("async_reset_data", data[0], 0);
    rd_en[0] = 1'b0;
    @(posedge clk_i);
    #1 reset_i = 1'b0;
    @(posedge clk_i);
    #1;
    request(0, 0, Blk0, 7);

    // Load word 1 at the fill-beat-1 edge: the fill sees the old word.
    fork
      request(0, 0, Blk0, 7);
      begin
        repeat (5) @(posedge clk_i);
        #1;
        load_en[0]   = 1'b1;
        load_addr[0] = WaW'(1);
        load_data[0] = 32'hDEADBEEF;
        @(posedge clk_i);
        #1 load_en[0] = 1'b0;
      end
    join
    request(0, 0, Blk0New, 7);

    repeat (3) @(posedge clk_i);
    #1;
    chk("pending_expectations", DataW'(exp_q0.size() + exp_q1.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
